// File: rtl/pc_sequencer_if.sv
// Bus between the PC sequencer and its surroundings: redirect requests and debug
// controls in, next-PC selection, write enable and status out.
interface pc_sequencer_if #(
   parameter int NBITS    = 32,
   parameter int CNT_BITS = 32
) ();
   logic                i_start;
   logic                i_mode_step;
   logic                i_step;
   logic                i_stall;
   logic                i_halt;
   logic [NBITS-1:0]    i_pc;
   logic                i_branch_taken;
   logic [NBITS-1:0]    i_branch_target;
   logic                i_jump;
   logic [NBITS-1:0]    i_jump_target;
   logic                i_jr;
   logic [NBITS-1:0]    i_jr_target;
   logic [NBITS-1:0]    o_npc;
   logic                o_pc_we;
   logic                o_flush;
   logic                o_halted;
   logic [1:0]          o_state;
   logic [CNT_BITS-1:0] o_cycle_count;

   // Pipeline, hazard unit and debug unit drive the i_* side.
   modport master (
      output i_start, i_mode_step, i_step, i_stall, i_halt, i_pc,
             i_branch_taken, i_branch_target, i_jump, i_jump_target,
             i_jr, i_jr_target,
      input  o_npc, o_pc_we, o_flush, o_halted, o_state, o_cycle_count
   );

   modport slave (
      input  i_start, i_mode_step, i_step, i_stall, i_halt, i_pc,
             i_branch_taken, i_branch_target, i_jump, i_jump_target,
             i_jr, i_jr_target,
      output o_npc, o_pc_we, o_flush, o_halted, o_state, o_cycle_count
   );
endinterface

// File: rtl/pc_sequencer.sv
// Next-PC selection and PC write-enable sequencing for the MIPS core:
// free-run, debug single-step, hazard stall and terminal HALT.
module pc_sequencer #(
   parameter int NBITS    = 32,
   parameter int CNT_BITS = 32
) (
   input  logic                i_clk,
   input  logic                i_reset,
   pc_sequencer_if.slave       bus
);

   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      RUN    = 2'b01,
      STEP   = 2'b10,
      HALTED = 2'b11
   } state_t;

   state_t              r_state;
   logic [CNT_BITS-1:0] r_cycle_count;

   logic [NBITS-1:0]    w_seq_pc;
   logic [NBITS-1:0]    w_npc;
   logic                w_active;
   logic                w_pc_we;
   logic                w_redirect;

   // NOTE: every path through an always_comb assigns w_npc, so no latch is inferred.
   always_comb begin
      w_seq_pc = bus.i_pc + NBITS'(4);
      if (bus.i_jr)
         w_npc = bus.i_jr_target;
      else if (bus.i_jump)
         w_npc = bus.i_jump_target;
      else if (bus.i_branch_taken)
         w_npc = bus.i_branch_target;
      else
         w_npc = w_seq_pc;
   end

   // The PC register samples on negedge, so these stay combinational from the
   // posedge-registered state and settle well before it.
   assign w_active   = (r_state == RUN) || (r_state == STEP);
   assign w_pc_we    = w_active && !bus.i_stall && !bus.i_halt;
   assign w_redirect = bus.i_jr || bus.i_jump || bus.i_branch_taken;

   // NOTE: state registers use non-blocking assignments so every flop samples
   // pre-edge values regardless of statement order.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state       <= IDLE;
         r_cycle_count <= '0;
      end else begin
         if (w_pc_we && (r_cycle_count != '1))
            r_cycle_count <= r_cycle_count + CNT_BITS'(1);

         case (r_state)
            IDLE: begin
               if ((bus.i_start || bus.i_step) && bus.i_mode_step)
                  r_state <= STEP;
               else if (bus.i_start)
                  r_state <= RUN;
            end
            RUN: begin
               if (bus.i_halt)
                  r_state <= HALTED;
            end
            STEP: begin
               // A stalled step is held here until it can issue its one update.
               if (bus.i_halt)
                  r_state <= HALTED;
               else if (!bus.i_stall)
                  r_state <= IDLE;
            end
            HALTED: r_state <= HALTED;
            default: r_state <= IDLE;
         endcase
      end
   end

   assign bus.o_npc         = w_npc;
   assign bus.o_pc_we       = w_pc_we;
   assign bus.o_flush       = w_pc_we && w_redirect;
   assign bus.o_halted      = (r_state == HALTED);
   assign bus.o_state       = r_state;
   assign bus.o_cycle_count = r_cycle_count;

endmodule
